dly_tap_ctrl: RTL and testbench

DLY_TAP_CTRL -- requirements
Module: dly_tap_ctrl

---
 rtl/dly_tap_ctrl.sv | 136 +++++++++++++
 tb/tb_dly_tap_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dly_tap_ctrl.sv
// Per-tap delay value store feeding the delay mux.
// Ports: CLK, RST (async low), DLY_* command in, DLY_TAPn_VAL / flags out.
module dly_tap_ctrl #(
  parameter logic [5:0] INIT_TAP = 6'd0,
  parameter int         ADJ_STEP = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] DLY_ADDR,
  input  logic       DLY_LOAD,
  input  logic [5:0] DLY_LOAD_VAL,
  input  logic       DLY_ADJ,
  input  logic       DLY_INCDEC,
  output logic [5:0] DLY_TAP0_VAL,
  output logic [5:0] DLY_TAP1_VAL,
  output logic [5:0] DLY_TAP2_VAL,
  output logic [5:0] DLY_TAP3_VAL,
  output logic [5:0] DLY_TAP4_VAL,
  output logic [5:0] DLY_TAP5_VAL,
  output logic [5:0] DLY_TAP6_VAL,
  output logic [5:0] DLY_TAP7_VAL,
  output logic [5:0] DLY_TAP8_VAL,
  output logic [5:0] DLY_TAP9_VAL,
  output logic [5:0] DLY_TAP10_VAL,
  output logic [5:0] DLY_TAP11_VAL,
  output logic [5:0] DLY_TAP12_VAL,
  output logic [5:0] DLY_TAP13_VAL,
  output logic [5:0] DLY_TAP14_VAL,
  output logic [5:0] DLY_TAP15_VAL,
  output logic [5:0] DLY_TAP16_VAL,
  output logic [5:0] DLY_TAP17_VAL,
  output logic [5:0] DLY_TAP18_VAL,
  output logic [5:0] DLY_TAP19_VAL,
  output logic       DLY_ACK,
  output logic       DLY_SAT,
  output logic       DLY_ERR
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam int         NTAP = 20;
  localparam logic [6:0] STEP = 7'(ADJ_STEP);

  logic [5:0] tap_q [NTAP];
  state_t     state_q;

  logic       addr_ok;
  logic       adj_go;
  logic       cmd;
  logic       clip;
  logic [5:0] cur;
  logic [5:0] adj_val;
  logic [5:0] nxt;
  logic [6:0] sum;

  always_comb begin
    cur = '0;
    for (int i = 0; i < NTAP; i++) begin
      if (DLY_ADDR == 5'(i)) cur = tap_q[i];
    end
  end

  assign addr_ok = DLY_ADDR < 5'(NTAP);
  // One step per assertion: only an IDLE-state request counts.
  assign adj_go  = (state_q == IDLE) && DLY_ADJ;
  assign cmd     = DLY_LOAD || adj_go;

  // Saturating step computed one bit wider so it never wraps.
  always_comb begin
    sum     = {1'b0, cur} + STEP;
    clip    = 1'b0;
    adj_val = cur;
    if (DLY_INCDEC) begin
      if (sum > 7'd63) begin
        adj_val = 6'd63;
        clip    = 1'b1;
      end else begin
        adj_val = sum[5:0];
      end
    end else begin
      if ({1'b0, cur} < STEP) begin
        adj_val = '0;
        clip    = 1'b1;
      end else begin
        adj_val = cur - STEP[5:0];
      end
    end
  end

  // Load beats a same-edge adjust.
  assign nxt = DLY_LOAD ? DLY_LOAD_VAL : adj_val;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NTAP; i++) tap_q[i] <= INIT_TAP;
      state_q <= IDLE;
      DLY_ACK <= 1'b0;
      DLY_SAT <= 1'b0;
      DLY_ERR <= 1'b0;
    end else begin
      DLY_ACK <= cmd && addr_ok;
      DLY_SAT <= adj_go && !DLY_LOAD && addr_ok && clip;
      DLY_ERR <= cmd && !addr_ok;
      case (state_q)
        IDLE:    if (DLY_ADJ)  state_q <= HOLD;
        HOLD:    if (!DLY_ADJ) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      for (int i = 0; i < NTAP; i++) begin
        if (cmd && addr_ok && DLY_ADDR == 5'(i)) tap_q[i] <= nxt;
      end
    end
  end

  assign DLY_TAP0_VAL  = tap_q[0];
  assign DLY_TAP1_VAL  = tap_q[1];
  assign DLY_TAP2_VAL  = tap_q[2];
  assign DLY_TAP3_VAL  = tap_q[3];
  assign DLY_TAP4_VAL  = tap_q[4];
  assign DLY_TAP5_VAL  = tap_q[5];
  assign DLY_TAP6_VAL  = tap_q[6];
  assign DLY_TAP7_VAL  = tap_q[7];
  assign DLY_TAP8_VAL  = tap_q[8];
  assign DLY_TAP9_VAL  = tap_q[9];
  assign DLY_TAP10_VAL = tap_q[10];
  assign DLY_TAP11_VAL = tap_q[11];
  assign DLY_TAP12_VAL = tap_q[12];
  assign DLY_TAP13_VAL = tap_q[13];
  assign DLY_TAP14_VAL = tap_q[14];
  assign DLY_TAP15_VAL = tap_q[15];
  assign DLY_TAP16_VAL = tap_q[16];
  assign DLY_TAP17_VAL = tap_q[17];
  assign DLY_TAP18_VAL = tap_q[18];
  assign DLY_TAP19_VAL = tap_q[19];

endmodule

// File: tb/tb_dly_tap_ctrl.sv
// Scoreboard bench for dly_tap_ctrl.
// Two instances: step 1 / init 5, and step 4 / init 0.
module tb_dly_tap_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST;
  logic [4:0] a_addr, b_addr;
  logic       a_load, a_adj, a_inc;
  logic       b_load, b_adj, b_inc;
  logic [5:0] a_val, b_val;
  logic [5:0] ta [20];
  logic [5:0] tb [20];
  logic       a_ack, a_sat, a_err;
  logic       b_ack, b_sat, b_err;

  typedef struct {
    logic       ack;
    logic       sat;
    logic       err;
    logic [4:0] addr;
    logic [5:0] val;
  } exp_t;

  exp_t       qa [$];
  exp_t       qb [$];
  logic [5:0] ea [20];
  int         pass_n = 0;
  int         tot_n  = 0;

  dly_tap_ctrl #(.INIT_TAP(6'd5), .ADJ_STEP(1)) u_a (
    .CLK(CLK), .RST(RST),
    .DLY_ADDR(a_addr), .DLY_LOAD(a_load), .DLY_LOAD_VAL(a_val),
    .DLY_ADJ(a_adj), .DLY_INCDEC(a_inc),
    .DLY_TAP0_VAL(ta[0]),   .DLY_TAP1_VAL(ta[1]),
    .DLY_TAP2_VAL(ta[2]),   .DLY_TAP3_VAL(ta[3]),
    .DLY_TAP4_VAL(ta[4]),   .DLY_TAP5_VAL(ta[5]),
    .DLY_TAP6_VAL(ta[6]),   .DLY_TAP7_VAL(ta[7]),
    .DLY_TAP8_VAL(ta[8]),   .DLY_TAP9_VAL(ta[9]),
    .DLY_TAP10_VAL(ta[10]), .DLY_TAP11_VAL(ta[11]),
    .DLY_TAP12_VAL(ta[12]), .DLY_TAP13_VAL(ta[13]),
    .DLY_TAP14_VAL(ta[14]), .DLY_TAP15_VAL(ta[15]),
    .DLY_TAP16_VAL(ta[16]), .DLY_TAP17_VAL(ta[17]),
    .DLY_TAP18_VAL(ta[18]), .DLY_TAP19_VAL(ta[19]),
    .DLY_ACK(a_ack), .DLY_SAT(a_sat), .DLY_ERR(a_err)
  );

  dly_tap_ctrl #(.INIT_TAP(6'd0), .ADJ_STEP(4)) u_b (
    .CLK(CLK), .RST(RST),
    .DLY_ADDR(b_addr), .DLY_LOAD(b_load), .DLY_LOAD_VAL(b_val),
    .DLY_ADJ(b_adj), .DLY_INCDEC(b_inc),
    .DLY_TAP0_VAL(tb[0]),   .DLY_TAP1_VAL(tb[1]),
    .DLY_TAP2_VAL(tb[2]),   .DLY_TAP3_VAL(tb[3]),
    .DLY_TAP4_VAL(tb[4]),   .DLY_TAP5_VAL(tb[5]),
    .DLY_TAP6_VAL(tb[6]),   .DLY_TAP7_VAL(tb[7]),
    .DLY_TAP8_VAL(tb[8]),   .DLY_TAP9_VAL(tb[9]),
    .DLY_TAP10_VAL(tb[10]), .DLY_TAP11_VAL(tb[11]),
    .DLY_TAP12_VAL(tb[12]), .DLY_TAP13_VAL(tb[13]),
    .DLY_TAP14_VAL(tb[14]), .DLY_TAP15_VAL(tb[15]),
    .DLY_TAP16_VAL(tb[16]), .DLY_TAP17_VAL(tb[17]),
    .DLY_TAP18_VAL(tb[18]), .DLY_TAP19_VAL(tb[19]),
    .DLY_ACK(b_ack), .DLY_SAT(b_sat), .DLY_ERR(b_err)
  );

  task automatic chk(input string nm, input int got, input int want);
    tot_n++;
    if (got == want) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, want);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_a(input logic ack, input logic sat, input logic err,
                        input logic [4:0] ad, input logic [5:0] v);
    exp_t e;
    e.ack = ack; e.sat = sat; e.err = err; e.addr = ad; e.val = v;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic ack, input logic sat, input logic err,
                        input logic [4:0] ad, input logic [5:0] v);
    exp_t e;
    e.ack = ack; e.sat = sat; e.err = err; e.addr = ad; e.val = v;
    qb.push_back(e);
  endtask

  task automatic chk_taps_a(input string nm);
    for (int i = 0; i < 20; i++)
      chk($sformatf("%s_tap%0d", nm, i), int'(ta[i]), int'(ea[i]));
  endtask

  // Monitors: every flag pulse must match the head of its queue.
  exp_t ma, mb;
  always @(negedge CLK) begin
    if (a_ack || a_sat || a_err) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_flag", 1, 0);
      end else begin
        ma = qa.pop_front();
        chk("a_ack", int'(a_ack), int'(ma.ack));
        chk("a_sat", int'(a_sat), int'(ma.sat));
        chk("a_err", int'(a_err), int'(ma.err));
        if (ma.ack)
          chk($sformatf("a_tap%0d", ma.addr), int'(ta[ma.addr]), int'(ma.val));
      end
    end
  end

  always @(negedge CLK) begin
    if (b_ack || b_sat || b_err) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_flag", 1, 0);
      end else begin
        mb = qb.pop_front();
        chk("b_ack", int'(b_ack), int'(mb.ack));
        chk("b_sat", int'(b_sat), int'(mb.sat));
        chk("b_err", int'(b_err), int'(mb.err));
        if (mb.ack)
          chk($sformatf("b_tap%0d", mb.addr), int'(tb[mb.addr]), int'(mb.val));
      end
    end
  end

  initial begin
    RST = 1'b0;
    a_addr = '0; a_load = 0; a_adj = 0; a_inc = 0; a_val = '0;
    b_addr = '0; b_load = 0; b_adj = 0; b_inc = 0; b_val = '0;
    for (int i = 0; i < 20; i++) ea[i] = 6'd5;

    // Commands during reset must be ignored.
    a_load = 1; a_addr = 5'd7; a_val = 6'd42;
    repeat (3) cyc();
    chk_taps_a("in_rst");
    a_load = 0;
    RST = 1'b1;
    chk("rst_ack", int'(a_ack), 0);
    chk("rst_sat", int'(a_sat), 0);
    chk("rst_err", int'(a_err), 0);
    chk_taps_a("rst_rel");
    cyc();

    // Single load.
    a_load = 1; a_addr = 5'd7; a_val = 6'd42;
    push_a(1, 0, 0, 5'd7, 6'd42);
    cyc();
    a_load = 0;
    ea[7] = 6'd42;
    cyc();
    chk_taps_a("load7");

    // Level load: two cycles, two acks.
    a_load = 1; a_addr = 5'd8; a_val = 6'd1;
    push_a(1, 0, 0, 5'd8, 6'd1);
    cyc();
    a_val = 6'd2;
    push_a(1, 0, 0, 5'd8, 6'd2);
    cyc();
    a_load = 0;
    ea[8] = 6'd2;
    cyc();

    // Adjust held 10 cycles gives one step.
    a_load = 1; a_addr = 5'd3; a_val = 6'd10;
    push_a(1, 0, 0, 5'd3, 6'd10);
    cyc();
    a_load = 0;
    a_adj = 1; a_inc = 1;
    push_a(1, 0, 0, 5'd3, 6'd11);
    cyc();
    a_addr = 5'd9; a_inc = 0;
    repeat (9) cyc();
    a_adj = 0;
    cyc();
    ea[3] = 6'd11;
    chk_taps_a("hold");
    a_adj = 1; a_addr = 5'd3; a_inc = 1;
    push_a(1, 0, 0, 5'd3, 6'd12);
    cyc();
    a_adj = 0;
    cyc();
    ea[3] = 6'd12;
    chk("reassert_tap3", int'(ta[3]), 12);

    // Decrement at zero clips.
    a_load = 1; a_addr = 5'd2; a_val = 6'd0;
    push_a(1, 0, 0, 5'd2, 6'd0);
    cyc();
    a_load = 0;
    a_adj = 1; a_inc = 0;
    push_a(1, 1, 0, 5'd2, 6'd0);
    cyc();
    a_adj = 0;
    cyc();
    ea[2] = 6'd0;

    // Load beats adjust; FSM still goes to HOLD.
    a_load = 1; a_adj = 1; a_inc = 1; a_addr = 5'd4; a_val = 6'd20;
    push_a(1, 0, 0, 5'd4, 6'd20);
    cyc();
    a_load = 0;
    repeat (2) cyc();
    // Load while in HOLD.
    a_load = 1; a_addr = 5'd5; a_val = 6'd33;
    push_a(1, 0, 0, 5'd5, 6'd33);
    cyc();
    a_load = 0;
    cyc();
    // Bad address load.
    a_load = 1; a_addr = 5'd25; a_val = 6'd7;
    push_a(0, 0, 1, 5'd25, 6'd0);
    cyc();
    a_load = 0;
    cyc();
    a_adj = 0;
    cyc();
    ea[4] = 6'd20;
    ea[5] = 6'd33;
    chk_taps_a("prio_err");

    // Bad address adjust still moves FSM to HOLD.
    a_adj = 1; a_inc = 1; a_addr = 5'd31;
    push_a(0, 0, 1, 5'd31, 6'd0);
    repeat (2) cyc();
    a_adj = 0;
    cyc();
    chk_taps_a("adj_err");

    // Reset mid-HOLD with ack pulsing.
    a_adj = 1; a_inc = 1; a_addr = 5'd3;
    cyc();
    chk("pre_rst_ack", int'(a_ack), 1);
    chk("pre_rst_tap3", int'(ta[3]), 13);
    RST = 1'b0;
    #1;
    chk("mid_rst_ack", int'(a_ack), 0);
    for (int i = 0; i < 20; i++) ea[i] = 6'd5;
    chk_taps_a("mid_rst");
    cyc();
    RST = 1'b1;
    push_a(1, 0, 0, 5'd3, 6'd6);
    cyc();
    a_adj = 0;
    cyc();
    ea[3] = 6'd6;
    chk_taps_a("post_rst");

    // Step-4 instance saturation cases.
    b_load = 1; b_addr = 5'd0; b_val = 6'd61;
    push_b(1, 0, 0, 5'd0, 6'd61);
    cyc();
    b_addr = 5'd1; b_val = 6'd2;
    push_b(1, 0, 0, 5'd1, 6'd2);
    cyc();
    b_addr = 5'd2; b_val = 6'd59;
    push_b(1, 0, 0, 5'd2, 6'd59);
    cyc();
    b_load = 0;
    b_adj = 1; b_inc = 1; b_addr = 5'd0;
    push_b(1, 1, 0, 5'd0, 6'd63);
    cyc();
    b_adj = 0;
    cyc();
    b_adj = 1; b_inc = 0; b_addr = 5'd1;
    push_b(1, 1, 0, 5'd1, 6'd0);
    cyc();
    b_adj = 0;
    cyc();
    b_adj = 1; b_inc = 1; b_addr = 5'd0;
    push_b(1, 1, 0, 5'd0, 6'd63);
    cyc();
    b_adj = 0;
    cyc();
    b_adj = 1; b_inc = 1; b_addr = 5'd2;
    push_b(1, 0, 0, 5'd2, 6'd63);
    cyc();
    b_adj = 0;
    cyc();
    b_adj = 1; b_inc = 1; b_addr = 5'd1;
    push_b(1, 0, 0, 5'd1, 6'd4);
    cyc();
    b_adj = 0;
    repeat (3) cyc();
    chk("b_tap5_untouched", int'(tb[5]), 0);

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
